// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter. A store to TXD queues a byte; bytes go out 8N1, LSB first.
// Latency: tx falls two clk edges after a TXD store into an empty FIFO; one frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none on the bus. A store to a full FIFO is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   addr      CPU byte address (TXD 0x40000018 write-only, CON 0x40000020 read)
//   wdata     store data; only [7:0] is used
//   MemWrite  store strobe
//   MemRead   load strobe; a CON load also clears overflow
//   rdata     combinational load data: {28'b0, overflow, fifo_empty, fifo_full, busy}
//   tx        registered serial output, idle high
module uart_tx_periph #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] CON_ADDR = 32'h4000_0020;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic wr_txd, rd_con, fifo_full, fifo_empty, busy, push, pop, baud_end;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign wr_txd     = MemWrite && (addr == TXD_ADDR);
    assign rd_con     = MemRead && (addr == CON_ADDR);
    assign fifo_full  = (count_q == OCC_FULL);
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != IDLE);
    assign baud_end   = (baud_q == BAUD_LAST);

    // The FSM drains the head whenever it sits in IDLE; a store to a full FIFO
    // is still accepted in that cycle because the pop frees a slot.
    assign pop  = (state_q == IDLE) && !fifo_empty;
    assign push = wr_txd && (!fifo_full || pop);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // A dropped store wins over a simultaneous CON load so the loss is never hidden.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_txd && !push) ovf_d = 1'b1;
        else if (rd_con)     ovf_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is computed from the next state so the registered line lines up
    // exactly with the state it belongs to.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shift_d[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy, not contents, decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    always_comb begin
        rdata = '0;
        if (rd_con) rdata = {28'b0, ovf_q, fifo_empty, fifo_full, busy};
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
module tb_uart_tx_periph;

    localparam int N = 4;
    localparam int D = 4;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] rdata;
    logic        tx;

    uart_tx_periph #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemWrite(MemWrite), .MemRead(MemRead), .rdata(rdata), .tx(tx)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int vecs = 0;
    int errs = 0;

    typedef struct { logic [7:0] b; int start; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] rd_exp[$];

    // Reference model: FIFO contents, sticky flag, and the edge at which the
    // transmitter becomes idle again (a frame popped at edge e ends at e+10N).
    logic [7:0] m_fifo[$];
    logic       m_ovf = 1'b0;
    int         m_idle_at = -1000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] con_model();
        logic busy;
        busy = (edge_n < m_idle_at);
        return {28'b0, m_ovf, m_fifo.size() == 0, m_fifo.size() == D, busy};
    endfunction

    // Drive one cycle of bus activity (called at a negedge) and advance the model
    // across the coming rising edge.
    task automatic apply(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic re);
        int e;
        exp_t x;
        MemWrite = we; addr = a; wdata = wd; MemRead = re;
        if (re) rd_exp.push_back((a == CON) ? con_model() : 32'h0);
        e = edge_n + 1;
        if ((e - 1) >= m_idle_at && m_fifo.size() > 0) begin
            x.b = m_fifo.pop_front();
            x.start = e;
            exp_q.push_back(x);
            m_idle_at = e + 10 * N;
        end
        if (re && a == CON) m_ovf = 1'b0;
        if (we && a == TXD) begin
            if (m_fifo.size() < D) m_fifo.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] b);
        apply(1'b1, TXD, {$urandom_range(0, 255), 16'h0, b}, 1'b0);
    endtask

    task automatic rd_con();
        apply(1'b0, CON, 32'h0, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (m_fifo.size() > 0 || edge_n <= m_idle_at + 2); i++)
            idle(1);
        idle(2);
    endtask

    // Reset is asserted with a TXD store on the bus, which must be ignored.
    task automatic do_reset(input int n);
        reset = 1'b1; MemWrite = 1'b1; addr = TXD; wdata = 32'hEE; MemRead = 1'b0;
        #1;
        chk("tx_high_in_reset", {31'b0, tx}, 32'h1);
        exp_q.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
        m_idle_at = -1000;
        repeat (n) @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0; addr = '0;
    endtask

    // Line monitor: detects a start bit, samples every bit mid-period and
    // compares the frame against the scoreboard.
    int         in_frame = 0;
    int         fs = 0;
    logic [9:0] bits = '0;
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 0;
        end else if (in_frame == 0) begin
            if (tx === 1'b0) begin
                in_frame = 1;
                fs = edge_n;
            end
        end else if (((edge_n - fs) % N) == N / 2) begin
            bits[(edge_n - fs) / N] = tx;
            if ((edge_n - fs) / N == 9) begin
                in_frame = 0;
                chk("framing", {30'b0, bits[0], bits[9]}, 32'h1);
                if (exp_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL unexpected_frame: got byte %h started at edge %0d, expected no frame", bits[8:1], fs);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("tx_byte", {24'b0, bits[8:1]}, {24'b0, x.b});
                    chk("start_edge", fs, x.start);
                end
            end
        end
    end

    // Load monitor: every issued load has its expected data queued.
    always @(negedge clk) begin
        #2;
        if (MemRead && !reset) begin
            if (rd_exp.size() == 0) begin
                vecs++; errs++;
                $display("FAIL rdata_unexpected: got %h expected no load", rdata);
            end else begin
                chk("rdata", rdata, rd_exp.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset(3);

        // Idle after reset: line high, CON = empty only.
        idle(20);
        rd_con();
        idle(1);

        // Single byte, with status sampled mid-frame and after.
        wr(8'hA5);
        for (int i = 0; i < 50; i++) begin
            if (i == 5 || i == 30 || i == 49) rd_con();
            else idle(1);
        end

        // Five back-to-back: one in flight, four fill the FIFO.
        for (int b = 1; b <= 5; b++) wr(8'(b * 8'h11));
        rd_con();
        wait_idle();
        rd_con();

        // Six back-to-back: sixth dropped, overflow reported once then cleared.
        for (int b = 0; b < 6; b++) wr(8'h61 + 8'(b));
        rd_con();
        rd_con();
        wait_idle();
        rd_con();

        // Reset mid-frame with two bytes queued.
        wr(8'hC3); wr(8'h3C); wr(8'h5A);
        idle(14);
        do_reset(2);
        rd_con();
        idle(60);
        rd_con();

        // Store to a full FIFO on the very edge the transmitter pops.
        for (int b = 0; b < 5; b++) wr(8'h80 + 8'(b));
        for (int i = 0; i < 200 && edge_n != m_idle_at; i++) idle(1);
        apply(1'b1, TXD, 32'h99, 1'b1);
        rd_con();
        wait_idle();
        rd_con();

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    wr(8'($urandom_range(0, 255)));
                2:       rd_con();
                3:       apply(1'b1, CON, $urandom, 1'b0);
                4:       apply(1'b0, TXD + 32'($urandom_range(0, 3) * 4), 32'h0, 1'b1);
                5:       apply(1'b1, TXD, $urandom, 1'b1);
                default: idle(1);
            endcase
        end
        wait_idle();
        rd_con();
        idle(5);

        chk("all_frames_seen", exp_q.size(), 0);
        chk("all_loads_seen", rd_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, giving clk cycles per serial bit (9600 baud at 50 MHz).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the transmit FIFO entry count (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port addr, input, 32 bits: CPU data-bus byte address.
REQ-006 The block SHALL have port wdata, input, 32 bits: CPU store data.
REQ-007 The block SHALL have port MemWrite, input, 1 bit: store strobe, sampled every cycle.
REQ-008 The block SHALL have port MemRead, input, 1 bit: load strobe.
REQ-009 The block SHALL have port rdata, output, 32 bits: load data, combinational from addr/MemRead.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-011 Register map SHALL be: 0x40000018 TXD (write-only), 0x40000020 CON (read); other addresses are ignored and read 0.
REQ-012 A store to TXD with FIFO not full SHALL push wdata[7:0] into the FIFO on that clock edge.
REQ-013 A store to TXD with FIFO full SHALL drop the byte and set sticky overflow flag.
REQ-014 CON read value SHALL be {28'b0, overflow, fifo_empty, fifo_full, busy}, with busy = state not IDLE.
REQ-015 A load of CON (MemRead=1, addr=CON) SHALL clear overflow on that clock edge; a simultaneous overflowing push SHALL leave overflow set.
REQ-016 FIFO SHALL use wrapping read/write pointers plus an occupancy count 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
REQ-017 Simultaneous push and pop SHALL keep count unchanged, including when full (push accepted because pop frees a slot in the same cycle).
REQ-018 Transmit FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; if FIFO not empty, pop head into shift register, clear baud counter and bit index, go to START next cycle.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: tx=shift[0]; every CLKS_PER_BIT cycles shift right and increment bit index; after bit 7 period go to STOP. LSB first.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from start-bit falling edge to end of stop bit; a queued byte's start bit SHALL begin 1 cycle after the preceding stop bit ends (IDLE dwell of 1 cycle).
REQ-024 A byte written to an empty FIFO with FSM idle SHALL cause tx to fall at the second rising edge after the write edge (push edge, then pop/START edge).
REQ-025 Baud counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and wrap to 0 at CLKS_PER_BIT-1.
REQ-026 tx SHALL be driven from a register (glitch-free).

Reset
REQ-027 While reset=1: tx=1, state=IDLE, FIFO empty (pointers and count 0), overflow=0, baud counter and bit index 0; so CON reads 0x00000004.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (tx high asynchronously) and discard all queued bytes.
REQ-029 Writes during reset SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Reset then idle 20 cycles -> tx=1 throughout, CON reads 0x00000004.
REQ-031 Write TXD=0x000000A5 once -> tx low 2 edges later, bits 1,0,1,0,0,1,0,1 LSB first each 4 cycles, stop high, frame 40 cycles; busy=1 during frame, CON=0x4 after.
REQ-032 Write 0x11,0x22,0x33,0x44,0x55 back-to-back -> first popped, next four fill FIFO (full=1 after 5th), no overflow; five frames sent in order, 41-cycle spacing.
REQ-033 Six back-to-back writes -> sixth dropped, CON bit3=1; CON load clears it (next read bit3=0); only five bytes appear on tx.
REQ-034 Reset pulse at cycle 15 of a frame with 2 bytes queued -> tx=1 immediately, no further frames, CON=0x00000004.
REQ-035 Write when full in same cycle as FSM pop -> byte accepted, count stays 4, overflow=0.
